// File: rtl/spi_miso_receiver_if.sv
// spi_miso_receiver_if: host/slave-facing signals of the SPI receive engine.
// master: receive engine side; slave: register file plus SPI slave side.
interface spi_miso_receiver_if #(
    parameter int W = 32
);
    logic         receive_ready;
    logic [W-1:0] miso_data;
    logic         miso_dv;
    logic         miso_in;
    logic         spi_clk;

    modport master (
        input  receive_ready,
        input  miso_in,
        output miso_data,
        output miso_dv,
        output spi_clk
    );

    modport slave (
        output receive_ready,
        output miso_in,
        input  miso_data,
        input  miso_dv,
        input  spi_clk
    );
endinterface

// File: rtl/spi_miso_receiver.sv
// spi_miso_receiver: master-side SPI receive engine (CPOL=0), W-bit frames.
// Ports: clk, rst (async active-low), bus (master modport):
//   receive_ready in, miso_in in, spi_clk out, miso_data out, miso_dv out.
// Option: define MISO_LSB_FIRST_EN for LSB-first assembly (default MSB first).
module spi_miso_receiver #(
    parameter int W       = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_miso_receiver_if.master   bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [W-1:0]     data_q, data_d;
    logic             sck_q, sck_d;
    logic             dv_q, dv_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            sck_q   <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            sck_q   <= sck_d;
            dv_q    <= dv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        sck_d   = sck_q;
        dv_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                sck_d = 1'b0;
                if (bus.receive_ready) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        // Rising spi_clk: sample MISO on this same clk edge.
`ifdef MISO_LSB_FIRST_EN
                        shift_d = {bus.miso_in, shift_q[W-1:1]};
`else
                        shift_d = {shift_q[W-2:0], bus.miso_in};
`endif
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (cnt_q == CNT_FULL) begin
                        // Falling edge after the last sample closes the frame.
                        data_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
        endcase
    end

    assign bus.spi_clk   = sck_q;
    assign bus.miso_data = data_q;
    assign bus.miso_dv   = dv_q;
endmodule

// File: tb/tb_spi_miso_receiver.sv
// tb_spi_miso_receiver: randomized self-checking bench for spi_miso_receiver.
// Expected waveforms come from frame arithmetic, not from the RTL structure.
`timescale 1ns/1ps
module tb_spi_miso_receiver;
    localparam int W       = 32;
    localparam int CLK_DIV = 2;
    localparam int FRAME   = 2 * W * CLK_DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int dv_cyc = 0;
    int dv_prev = 0;
    logic [W-1:0] data_exp = '0;

    spi_miso_receiver_if #(.W(W)) bus ();

    spi_miso_receiver #(
        .W(W),
        .CLK_DIV(CLK_DIV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Word the host should see for a given on-wire bit stream
    // (sent[W-1] goes on the wire first).
    function automatic logic [W-1:0] rx_word(input logic [W-1:0] sent);
        logic [W-1:0] r;
        r = sent;
`ifdef MISO_LSB_FIRST_EN
        for (int i = 0; i < W; i++) r[i] = sent[W-1-i];
`endif
        return r;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.miso_in = 1'($urandom);
            tick;
            chk("idle_sck", bus.spi_clk, 1'b0);
            chk("idle_dv", bus.miso_dv, 1'b0);
            chk("idle_data", bus.miso_data, data_exp);
        end
    endtask

    // Starts a frame on the next edge. hold keeps receive_ready high
    // past entry; drop_at/abort_at are cycle indices within the frame.
    task automatic run_frame(input logic [W-1:0] sent, input bit hold,
                             input int drop_at, input int abort_at,
                             input bit noisy);
        int   rises;
        logic prev_sck;
        logic want_sck;
        rises    = 0;
        prev_sck = 1'b0;
        bus.receive_ready = 1'b1;
        bus.miso_in = noisy ? 1'($urandom) : sent[W-1];
        tick;
        if (!hold) bus.receive_ready = 1'b0;
        chk("entry_sck", bus.spi_clk, 1'b0);
        chk("entry_dv", bus.miso_dv, 1'b0);
        chk("entry_data", bus.miso_data, data_exp);
        for (int n = 1; n <= FRAME; n++) begin
            int k;
            bit samp;
            k    = (n - 1) / (2 * CLK_DIV);
            samp = (n % (2 * CLK_DIV)) == CLK_DIV;
            bus.miso_in = (noisy && !samp) ? 1'($urandom) : sent[W-1-k];
            if (n == drop_at) bus.receive_ready = 1'b0;
            tick;
            if (n == abort_at) begin
                rst = 1'b0;
                #1;
                data_exp = '0;
                chk("abort_sck", bus.spi_clk, 1'b0);
                chk("abort_dv", bus.miso_dv, 1'b0);
                chk("abort_data", bus.miso_data, '0);
                bus.receive_ready = 1'b0;
                tick;
                tick;
                chk("rst_sck", bus.spi_clk, 1'b0);
                chk("rst_dv", bus.miso_dv, 1'b0);
                #2 rst = 1'b1;
                return;
            end
            want_sck = ((n / CLK_DIV) % 2) == 1;
            if (bus.spi_clk === 1'b1 && prev_sck === 1'b0) rises++;
            prev_sck = bus.spi_clk;
            chk("sck", bus.spi_clk, want_sck);
            chk("dv", bus.miso_dv, n == FRAME);
            if (n == FRAME) begin
                data_exp = rx_word(sent);
                dv_prev  = dv_cyc;
                dv_cyc   = cyc;
            end
            chk("data", bus.miso_data, data_exp);
        end
        chk("rises", rises, W);
    endtask

    initial begin
        logic [W-1:0] w;
        bit hold;
        bus.receive_ready = 1'b0;
        bus.miso_in = 1'b0;
        #3 rst = 1'b0;
        #20;
        chk("rst_sck", bus.spi_clk, 1'b0);
        chk("rst_dv", bus.miso_dv, 1'b0);
        chk("rst_data", bus.miso_data, '0);
        rst = 1'b1;

        idle_cycles(300);

        run_frame(32'hA5A5_0F0F, 1'b0, -1, -1, 1'b0);
        chk("single_lat", dv_cyc - (cyc - 0), 0);
        idle_cycles(10);

        run_frame(32'hFFFF_FFFF, 1'b1, -1, -1, 1'b0);
        run_frame(32'h0000_0001, 1'b0, -1, -1, 1'b0);
        chk("b2b_gap", dv_cyc - dv_prev, FRAME + 1);
        idle_cycles(10);

        run_frame(32'h1234_5678, 1'b1, 40, -1, 1'b1);
        idle_cycles(20);

        run_frame($urandom, 1'b1, -1, 60, 1'b0);
        idle_cycles(10);
        run_frame(32'hDEAD_BEEF, 1'b0, -1, -1, 1'b1);
        idle_cycles(5);

        run_frame(32'h8000_0000, 1'b0, -1, -1, 1'b0);
        chk("order", bus.miso_data, rx_word(32'h8000_0000));
        idle_cycles(5);

        for (int i = 0; i < 8; i++) begin
            w    = $urandom;
            hold = (i < 7) && ($urandom_range(0, 1) == 1);
            run_frame(w, hold, -1, -1, 1'($urandom));
            if (!hold) idle_cycles($urandom_range(1, 6));
        end
        idle_cycles(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
